// File: rtl/um_egress_wrr_arbiter.sv
// Packet-granular weighted round-robin arbiter: pipeline FIFO vs CPU FIFO onto pktout.
// Latency: grant in cycle t, first pop in t+1, head word registered on pktout in t+2.
// Backpressure: pktout_ready gates only the grant; a granted packet drains regardless.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   pipe_empty/pipe_q/pipe_rdreq  pipeline packet FIFO (first-word-fall-through)
//   cpu_empty/cpu_q/cpu_rdreq     CPU packet FIFO (first-word-fall-through)
//   pktout_ready                  downstream can take one whole packet
//   pktout_data_wr/pktout_data    registered 134-bit word stream, [133:132] = 01 head/00 body/10 tail
//   pktout_data_valid(_wr)        packet-valid flag and its strobe, coincident with the tail word
//   pkt_cnt_pipe/pkt_cnt_cpu      wrapping per-source forwarded-packet counters
//   err_cnt                       saturating malformed-packet counter
module um_egress_wrr_arbiter #(
  parameter int unsigned W_PIPE = 4,  // pipeline packets per turn, 1..15
  parameter int unsigned W_CPU  = 1   // CPU packets per turn, 1..15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pipe_empty,
  input  logic [133:0] pipe_q,
  output logic         pipe_rdreq,
  input  logic         cpu_empty,
  input  logic [133:0] cpu_q,
  output logic         cpu_rdreq,
  input  logic         pktout_ready,
  output logic         pktout_data_wr,
  output logic [133:0] pktout_data,
  output logic         pktout_data_valid,
  output logic         pktout_data_valid_wr,
  output logic [31:0]  pkt_cnt_pipe,
  output logic [31:0]  pkt_cnt_cpu,
  output logic [15:0]  err_cnt
);

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_DROP} state_e;
  typedef enum logic {SRC_PIPE = 1'b0, SRC_CPU = 1'b1} src_e;

  function automatic logic [3:0] weight_of(src_e s);
    return (s == SRC_CPU) ? 4'(W_CPU) : 4'(W_PIPE);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e       state_q, state_d;
  src_e         ptr_q, ptr_d;       // source whose turn it is
  src_e         sel_q, sel_d;       // source currently being drained
  logic [3:0]   credit_q, credit_d; // packets left in ptr's turn
  logic         mid_q, mid_d;       // head of the current packet already popped

  logic         wr_q, wr_d;
  logic [133:0] data_q, data_d;
  logic         vld_q, vld_d;
  logic         vwr_q, vwr_d;
  logic [31:0]  cnt_pipe_q, cnt_pipe_d;
  logic [31:0]  cnt_cpu_q, cnt_cpu_d;
  logic [15:0]  err_q, err_d;

  logic         pop;
  logic         err_inc;

  // ---------------------------------------------------------------------------
  // Source views
  // ---------------------------------------------------------------------------
  src_e         oth_src;
  logic         ptr_empty, oth_empty;
  logic         sel_empty;
  logic [133:0] sel_word;
  logic [1:0]   sel_tag;

  assign oth_src   = (ptr_q == SRC_PIPE) ? SRC_CPU : SRC_PIPE;
  assign ptr_empty = (ptr_q == SRC_PIPE) ? pipe_empty : cpu_empty;
  assign oth_empty = (ptr_q == SRC_PIPE) ? cpu_empty : pipe_empty;
  assign sel_empty = (sel_q == SRC_PIPE) ? pipe_empty : cpu_empty;
  assign sel_word  = (sel_q == SRC_PIPE) ? pipe_q : cpu_q;
  assign sel_tag   = sel_word[133:132];

  // Grant choice: stay on ptr if it has data, otherwise hand the turn over.
  logic         grant_vld;
  logic         grant_switch;
  src_e         grant_src;
  logic [1:0]   grant_tag;

  always_comb begin
    grant_vld    = 1'b0;
    grant_switch = 1'b0;
    grant_src    = ptr_q;
    if (!ptr_empty) begin
      grant_vld = 1'b1;
    end else if (!oth_empty) begin
      grant_vld    = 1'b1;
      grant_switch = 1'b1;
      grant_src    = oth_src;
    end
  end

  assign grant_tag = (grant_src == SRC_PIPE) ? pipe_q[133:132] : cpu_q[133:132];

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    credit_d   = credit_q;
    mid_d      = mid_q;
    pop        = 1'b0;
    err_inc    = 1'b0;
    wr_d       = 1'b0;
    data_d     = data_q;
    vld_d      = 1'b0;
    vwr_d      = 1'b0;
    cnt_pipe_d = cnt_pipe_q;
    cnt_cpu_d  = cnt_cpu_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pktout_ready && grant_vld) begin
          sel_d = grant_src;
          mid_d = 1'b0;
          if (grant_switch) begin
            ptr_d    = oth_src;
            credit_d = weight_of(oth_src);
          end
          state_d = (grant_tag == TAG_HEAD) ? ST_XFER : ST_DROP;
        end
      end

      ST_XFER: begin
        // An empty FIFO mid-packet simply stalls the stream.
        if (!sel_empty) begin
          if (mid_q && (sel_tag == TAG_HEAD)) begin
            // Next packet started without a tail: close the output packet on
            // this word, flag it not-valid so downstream discards it, and
            // leave the new head in the FIFO for its own grant.
            wr_d    = 1'b1;
            data_d  = {TAG_TAIL, sel_word[131:0]};
            vwr_d   = 1'b1;
            err_inc = 1'b1;
            state_d = ST_IDLE;
          end else begin
            pop    = 1'b1;
            wr_d   = 1'b1;
            data_d = sel_word;
            mid_d  = 1'b1;
            if (sel_tag == TAG_TAIL) begin
              vld_d   = 1'b1;
              vwr_d   = 1'b1;
              state_d = ST_IDLE;
              if (sel_q == SRC_PIPE) cnt_pipe_d = cnt_pipe_q + 32'd1;
              else                   cnt_cpu_d  = cnt_cpu_q + 32'd1;
              // sel always equals ptr here, so the credit belongs to sel.
              if (credit_q <= 4'd1) begin
                ptr_d    = oth_src;
                credit_d = weight_of(oth_src);
              end else begin
                credit_d = credit_q - 4'd1;
              end
            end
          end
        end
      end

      ST_DROP: begin
        if (!sel_empty) begin
          if (sel_tag == TAG_HEAD) begin
            // Garbage ended at a real head: keep it for the next grant.
            err_inc = 1'b1;
            state_d = ST_IDLE;
          end else begin
            pop = 1'b1;
            if (sel_tag == TAG_TAIL) begin
              err_inc = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign err_d = (err_inc && (err_q != 16'hFFFF)) ? (err_q + 16'd1) : err_q;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= SRC_PIPE;
      sel_q      <= SRC_PIPE;
      credit_q   <= 4'(W_PIPE);
      mid_q      <= 1'b0;
      wr_q       <= 1'b0;
      data_q     <= '0;
      vld_q      <= 1'b0;
      vwr_q      <= 1'b0;
      cnt_pipe_q <= '0;
      cnt_cpu_q  <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      credit_q   <= credit_d;
      mid_q      <= mid_d;
      wr_q       <= wr_d;
      data_q     <= data_d;
      vld_q      <= vld_d;
      vwr_q      <= vwr_d;
      cnt_pipe_q <= cnt_pipe_d;
      cnt_cpu_q  <= cnt_cpu_d;
      err_q      <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // pop is only raised with the selected FIFO non-empty; rst forces both low.
  assign pipe_rdreq = pop && !rst && (sel_q == SRC_PIPE);
  assign cpu_rdreq  = pop && !rst && (sel_q == SRC_CPU);

  assign pktout_data_wr       = wr_q;
  assign pktout_data          = data_q;
  assign pktout_data_valid    = vld_q;
  assign pktout_data_valid_wr = vwr_q;
  assign pkt_cnt_pipe         = cnt_pipe_q;
  assign pkt_cnt_cpu          = cnt_cpu_q;
  assign err_cnt              = err_q;

endmodule
